// File: rtl/autoplay_ctl.sv
// Attract-mode autoplay: shares coin/start/throw between panel and script.
// Human activity preempts the script until the panel has been idle long enough.
module autoplay_ctl #(
   parameter logic [31:0] PRESCALE     = 32'd1_000_000,
   parameter logic [15:0] BOOT_DELAY   = 16'd5000,
   parameter logic [15:0] PULSE_LEN    = 16'd100,
   parameter logic [15:0] START_DELAY  = 16'd1000,
   parameter logic [15:0] THROW_PERIOD = 16'd300,
   parameter logic [7:0]  THROW_COUNT  = 8'd50,
   parameter logic [15:0] IDLE_TIMEOUT = 16'd30000
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic        enable,
   input  logic        btn_coin_n,
   input  logic        btn_start_n,
   input  logic        btn_throw_n,
   output logic        coin_n,
   output logic        start_n,
   output logic        throw_n,
   output logic        auto_active,
   output logic        human_active,
   output logic [15:0] game_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_COIN, S_GAP, S_START, S_PLAY, S_HUMAN
   } state_t;

   state_t      state, state_nxt;
   logic [2:0]  sync1, sync2;
   logic [31:0] pcnt;
   logic        tick;
   logic [15:0] tcnt, tcnt_nxt, tcnt_inc;
   logic [7:0]  thr, thr_nxt;
   logic [15:0] gc_nxt;
   logic        activity;
   logic        auto_coin, auto_start, auto_throw;
   logic        scripted;

   // {coin, start, throw}
   always_ff @(posedge sysclk) begin
      if (reset) begin
         sync1 <= 3'b111;
         sync2 <= 3'b111;
      end else begin
         sync1 <= {btn_coin_n, btn_start_n, btn_throw_n};
         sync2 <= sync1;
      end
   end

   assign activity = ~&sync2;
   assign tick     = (pcnt == PRESCALE - 32'd1);
   assign tcnt_inc = tick ? tcnt + 16'd1 : tcnt;

   always_ff @(posedge sysclk) begin
      if (reset)     pcnt <= '0;
      else if (tick) pcnt <= '0;
      else           pcnt <= pcnt + 32'd1;
   end

   assign scripted = (state == S_COIN) || (state == S_GAP) ||
                     (state == S_START) || (state == S_PLAY);

   always_comb begin
      state_nxt = state;
      tcnt_nxt  = tcnt_inc;
      thr_nxt   = thr;
      gc_nxt    = game_count;
      if (activity) begin
         state_nxt = S_HUMAN;
         tcnt_nxt  = '0;
      end else if (!enable && scripted) begin
         state_nxt = S_IDLE;
         tcnt_nxt  = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!enable) begin
                  tcnt_nxt = '0;
               end else if (tick && tcnt == BOOT_DELAY - 16'd1) begin
                  state_nxt = S_COIN;
                  tcnt_nxt  = '0;
               end
            end
            S_COIN: begin
               if (tick && tcnt == PULSE_LEN - 16'd1) begin
                  state_nxt = S_GAP;
                  tcnt_nxt  = '0;
               end
            end
            S_GAP: begin
               if (tick && tcnt == START_DELAY - 16'd1) begin
                  state_nxt = S_START;
                  tcnt_nxt  = '0;
               end
            end
            S_START: begin
               if (tick && tcnt == PULSE_LEN - 16'd1) begin
                  state_nxt = S_PLAY;
                  tcnt_nxt  = '0;
                  thr_nxt   = '0;
               end
            end
            S_PLAY: begin
               if (tick && tcnt == THROW_PERIOD - 16'd1) begin
                  tcnt_nxt = '0;
                  thr_nxt  = thr + 8'd1;
                  if (thr + 8'd1 == THROW_COUNT) begin
                     state_nxt = S_IDLE;
                     if (game_count != 16'hffff)
                        gc_nxt = game_count + 16'd1;
                  end
               end
            end
            S_HUMAN: begin
               if (tick && tcnt == IDLE_TIMEOUT - 16'd1) begin
                  state_nxt = S_IDLE;
                  tcnt_nxt  = '0;
               end
            end
            default: begin
               state_nxt = S_IDLE;
               tcnt_nxt  = '0;
            end
         endcase
      end
   end

   assign auto_coin  = (state == S_COIN);
   assign auto_start = (state == S_START);
   assign auto_throw = (state == S_PLAY) && (tcnt < PULSE_LEN);

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state        <= S_IDLE;
         tcnt         <= '0;
         thr          <= '0;
         game_count   <= '0;
         coin_n       <= 1'b1;
         start_n      <= 1'b1;
         throw_n      <= 1'b1;
         auto_active  <= 1'b0;
         human_active <= 1'b0;
      end else begin
         state        <= state_nxt;
         tcnt         <= tcnt_nxt;
         thr          <= thr_nxt;
         game_count   <= gc_nxt;
         coin_n       <= sync2[2] & ~auto_coin;
         start_n      <= sync2[1] & ~auto_start;
         throw_n      <= sync2[0] & ~auto_throw;
         auto_active  <= scripted;
         human_active <= (state == S_HUMAN);
      end
   end

endmodule

// File: tb/tb_autoplay_ctl.sv
// Directed bench for autoplay_ctl with small timing parameters.
// Edge numbers in comments count posedges after the last reset edge (e0).
module tb_autoplay_ctl;

   logic        sysclk, reset, enable, enable2;
   logic        btn_coin_n, btn_start_n, btn_throw_n;
   logic        coin_n, start_n, throw_n, auto_active, human_active;
   logic [15:0] game_count;
   logic        coin2_n, start2_n, throw2_n, auto2, human2;
   logic [15:0] gc2;

   int checks = 0;
   int failures = 0;
   int n, bad;

   autoplay_ctl #(
      .PRESCALE(32'd4), .BOOT_DELAY(16'd2), .PULSE_LEN(16'd2),
      .START_DELAY(16'd3), .THROW_PERIOD(16'd5), .THROW_COUNT(8'd3),
      .IDLE_TIMEOUT(16'd10)
   ) dut (
      .sysclk(sysclk), .reset(reset), .enable(enable),
      .btn_coin_n(btn_coin_n), .btn_start_n(btn_start_n),
      .btn_throw_n(btn_throw_n),
      .coin_n(coin_n), .start_n(start_n), .throw_n(throw_n),
      .auto_active(auto_active), .human_active(human_active),
      .game_count(game_count)
   );

   autoplay_ctl #(
      .PRESCALE(32'd4), .BOOT_DELAY(16'd2), .PULSE_LEN(16'd2),
      .START_DELAY(16'd3), .THROW_PERIOD(16'd5), .THROW_COUNT(8'd1),
      .IDLE_TIMEOUT(16'd10)
   ) dut2 (
      .sysclk(sysclk), .reset(reset), .enable(enable2),
      .btn_coin_n(1'b1), .btn_start_n(1'b1), .btn_throw_n(1'b1),
      .coin_n(coin2_n), .start_n(start2_n), .throw_n(throw2_n),
      .auto_active(auto2), .human_active(human2),
      .game_count(gc2)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic get(input int sel);
      case (sel)
         0:       return coin_n;
         1:       return start_n;
         2:       return throw_n;
         3:       return auto_active;
         4:       return human_active;
         default: return auto2;
      endcase
   endfunction

   // counts negedges until the signal shows v; -1 when the bound expires
   task automatic wait_val(input int sel, input logic v, input int bound,
                           output int cnt);
      cnt = 0;
      while (get(sel) !== v && cnt < bound) begin
         @(negedge sysclk);
         cnt++;
      end
      if (get(sel) !== v) cnt = -1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge sysclk);
      @(negedge sysclk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b1;
      enable2 = 1'b0;
      btn_coin_n = 1'b1;
      btn_start_n = 1'b1;
      btn_throw_n = 1'b1;

      // full scripted game
      do_reset();
      chk("rst_coin_n", coin_n, 1);
      chk("rst_start_n", start_n, 1);
      chk("rst_throw_n", throw_n, 1);
      chk("rst_auto", auto_active, 0);
      chk("rst_human", human_active, 0);
      chk("rst_games", game_count, 0);
      wait_val(0, 0, 20, n);  chk("coin_fall", n, 9);
      wait_val(0, 1, 20, n);  chk("coin_width", n, 8);
      wait_val(1, 0, 30, n);  chk("coin_to_start", n, 12);
      wait_val(1, 1, 20, n);  chk("start_width", n, 8);
      wait_val(2, 0, 20, n);  chk("first_throw", n, 0);
      chk("auto_in_play", auto_active, 1);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            wait_val(2, 0, 20, n);
            chk("throw_gap", n, 12);
         end
         wait_val(2, 1, 20, n);
         chk("throw_width", n, 8);
      end
      chk("games_mid", game_count, 0);
      wait_val(3, 0, 30, n);  chk("game_end", n, 12);
      chk("games_one", game_count, 1);
      wait_val(0, 0, 20, n);  chk("repeat_coin", n, 8);

      // disabled from reset
      enable = 1'b0;
      do_reset();
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge sysclk);
         if (!coin_n || !start_n || !throw_n || auto_active) bad++;
      end
      chk("disabled_quiet", bad, 0);
      enable = 1'b1;
      wait_val(0, 0, 20, n);
      chk("enable_coin_range", (n >= 9 && n <= 13), 1);
      chk("enable_coin_exact", n, 9);

      // human throw during play
      do_reset();
      wait_val(2, 0, 60, n);  chk("play_throw", n, 37);
      btn_throw_n = 1'b0;
      repeat (3) @(negedge sysclk);
      btn_throw_n = 1'b1;
      @(negedge sysclk);
      chk("human_on", human_active, 1);
      chk("human_auto_off", auto_active, 0);
      chk("human_throw_low", throw_n, 0);
      wait_val(2, 1, 10, n);  chk("human_throw_rel", n, 2);
      wait_val(4, 0, 60, n);  chk("human_timeout", n, 38);
      chk("human_games", game_count, 0);

      // enable dropped during START
      do_reset();
      wait_val(1, 0, 40, n);  chk("start_fall", n, 29);
      enable = 1'b0;
      @(negedge sysclk);
      chk("abort_latency", start_n, 0);
      @(negedge sysclk);
      chk("abort_start_n", start_n, 1);
      chk("abort_auto", auto_active, 0);
      chk("abort_human", human_active, 0);
      chk("abort_games", game_count, 0);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge sysclk);
         if (!coin_n || auto_active) bad++;
      end
      chk("abort_idle", bad, 0);

      // button on the final wrap
      enable = 1'b1;
      do_reset();
      repeat (93) @(negedge sysclk);
      btn_coin_n = 1'b0;
      @(negedge sysclk);
      btn_coin_n = 1'b1;
      repeat (3) @(negedge sysclk);
      chk("wrap_human", human_active, 1);
      chk("wrap_auto", auto_active, 0);
      chk("wrap_games", game_count, 0);

      // saturation on the single-throw instance
      enable = 1'b0;
      enable2 = 1'b1;
      do_reset();
      wait_val(5, 1, 20, n);  chk("sat_g1_start", n, 9);
      wait_val(5, 0, 80, n);  chk("sat_g1_len", n, 48);
      chk("sat_g1_count", gc2, 1);
      force dut2.game_count = 16'hffff;
      @(negedge sysclk);
      release dut2.game_count;
      @(negedge sysclk);
      chk("sat_forced", gc2, 16'hffff);
      wait_val(5, 1, 40, n);  chk("sat_g2_start", n, 6);
      wait_val(5, 0, 80, n);  chk("sat_g2_len", n, 48);
      chk("sat_hold", gc2, 16'hffff);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
